// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive stage.
//   ps2_state_e     : deserialiser FSM states
//   START_BIT/STOP_BIT/DATA_BITS : device-to-host frame layout
//   DEF_FILTER_LEN/DEF_TIMEOUT_CYC : default conditioning parameters
package ps2_pkg;

  typedef enum logic [1:0] {StIdle, StShift, StParity, StStop} ps2_state_e;

  localparam logic        START_BIT       = 1'b0;
  localparam logic        STOP_BIT        = 1'b1;
  localparam int unsigned DATA_BITS       = 8;
  localparam int unsigned DEF_FILTER_LEN  = 8;
  localparam int unsigned DEF_TIMEOUT_CYC = 28000;

endpackage

// File: rtl/ps2_rx_deser_if.sv
// Byte handshake between the PS/2 receiver and the translator FSM.
//   rx_read       : consumer pop request (one cycle)
//   rx_scan_code  : byte from the most recent accepted pop
//   rx_data_ready : FIFO non-empty
//   rx_error      : frame rejected pulse
//   rx_overflow   : valid frame dropped (FIFO full) pulse
interface ps2_rx_deser_if;
  logic       rx_read;
  logic [7:0] rx_scan_code;
  logic       rx_data_ready;
  logic       rx_error;
  logic       rx_overflow;

  modport master (
    input  rx_read,
    output rx_scan_code, rx_data_ready, rx_error, rx_overflow
  );

  modport slave (
    output rx_read,
    input  rx_scan_code, rx_data_ready, rx_error, rx_overflow
  );
endinterface

// File: rtl/ps2_rx_fifo.sv
// Small synchronous byte FIFO with a registered head read.
//   clk, reset     : clock, synchronous active-low reset
//   push/push_data : write request and byte
//   pop_req        : read request; ignored while empty
//   scan_code      : byte loaded by the last accepted pop
//   data_ready     : count != 0
//   overflow       : one-cycle pulse when a push is dropped
module ps2_rx_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop_req,
  output logic [7:0] scan_code,
  output logic       data_ready,
  output logic       overflow
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic [7:0]  head_q;
  logic        ovf_q;
  logic        empty, full, pop, push_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign pop     = pop_req && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        head_q   <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push_ok && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push_ok) count_q <= count_q - 1'b1;
      ovf_q <= push && full && !pop;
    end
  end

  assign scan_code  = head_q;
  assign data_ready = !empty;
  assign overflow   = ovf_q;
endmodule

// File: rtl/ps2_rx_deser.sv
// PS/2 device-to-host receiver: synchronises and filters the pins, deserialises
// 11-bit frames, checks start/parity/stop, aborts stalled frames and buffers
// accepted bytes.
//   clk, reset  : 14 MHz clock, synchronous active-low reset
//   ps2_clk_i   : raw PS/2 clock pin (asynchronous)
//   ps2_data_i  : raw PS/2 data pin (asynchronous)
//   rx          : byte handshake towards the translator
module ps2_rx_deser
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = DEF_FILTER_LEN,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ps2_clk_i,
  input  logic           ps2_data_i,
  ps2_rx_deser_if.master rx
);
  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned BW = $clog2(DATA_BITS);

  logic [1:0]    clk_sync_q, data_sync_q;
  logic          clk_s, data_s;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fall;

  ps2_state_e    state_q, state_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d, par_ok_q, par_ok_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          error_q, error_d;
  logic          push;

  assign clk_s  = clk_sync_q[1];
  assign data_s = data_sync_q[1];

  // Filtered level flips only after FILTER_LEN consecutive differing samples.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_s != filt_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) filt_d = clk_s;
      else                               fcnt_d = fcnt_q + 1'b1;
    end
  end

  assign fall = filt_q && !filt_d;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    par_ok_d  = par_ok_q;
    error_d   = 1'b0;
    push      = 1'b0;
    timer_d   = (state_q == StIdle || fall) ? '0 : timer_q + 1'b1;

    unique case (state_q)
      StIdle: if (fall) begin
        if (data_s == START_BIT) begin
          state_d   = StShift;
          bit_cnt_d = '0;
          par_d     = 1'b0;
        end else begin
          error_d = 1'b1;
        end
      end
      StShift: if (fall) begin
        shift_d   = {data_s, shift_q[7:1]};
        par_d     = par_q ^ data_s;
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == BW'(DATA_BITS - 1)) state_d = StParity;
      end
      StParity: if (fall) begin
        par_ok_d = par_q ^ data_s;  // odd parity over data + parity bit
        state_d  = StStop;
      end
      StStop: if (fall) begin
        if (data_s == STOP_BIT && par_ok_q) push    = 1'b1;
        else                                error_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Stalled frame: no fall for TIMEOUT_CYC cycles outside IDLE.
    if (state_q != StIdle && !fall && timer_q == TW'(TIMEOUT_CYC - 1)) begin
      error_d = 1'b1;
      state_d = StIdle;
      timer_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      clk_sync_q  <= '0;
      data_sync_q <= '0;
      filt_q      <= 1'b0;
      fcnt_q      <= '0;
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      par_ok_q    <= 1'b0;
      timer_q     <= '0;
      error_q     <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      filt_q      <= filt_d;
      fcnt_q      <= fcnt_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      par_ok_q    <= par_ok_d;
      timer_q     <= timer_d;
      error_q     <= error_d;
    end
  end

  assign rx.rx_error = error_q;

  ps2_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_data  (shift_q),
    .pop_req    (rx.rx_read),
    .scan_code  (rx.rx_scan_code),
    .data_ready (rx.rx_data_ready),
    .overflow   (rx.rx_overflow)
  );
endmodule

// File: tb/tb_ps2_rx_deser.sv
module tb_ps2_rx_deser;
  import ps2_pkg::*;

  localparam int HALF = 20;  // clk cycles per PS/2 half period

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  int n_cmp = 0;
  int n_fail = 0;
  int err_cnt = 0;
  int ovf_cnt = 0;

  ps2_rx_deser_if rx_if ();

  ps2_rx_deser dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk_i  (ps2_clk),
    .ps2_data_i (ps2_data),
    .rx         (rx_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rx_if.rx_error === 1'b1)    err_cnt++;
    if (rx_if.rx_overflow === 1'b1) ovf_cnt++;
  end

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic flip);
    return {1'b1, (~^b) ^ flip, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      ps2_data = f[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic flip);
    send_bits(mk_frame(b, flip), 0, 10);
    ps2_data = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    @(negedge clk);
    rx_if.rx_read = 1'b1;
    @(negedge clk);
    rx_if.rx_read = 1'b0;
    n_cmp++;
    if (rx_if.rx_scan_code !== exp) begin
      n_fail++;
      $display("FAIL %s: scan_code got %02h want %02h", name, rx_if.rx_scan_code, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, got, exp);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check_int("reset scan_code", int'(rx_if.rx_scan_code), 0);
    check_bit("reset ready", rx_if.rx_data_ready, 1'b0);
    check_bit("reset error", rx_if.rx_error, 1'b0);
    check_bit("reset overflow", rx_if.rx_overflow, 1'b0);
    reset = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_single;
    logic [10:0] f;
    int e0;
    e0 = err_cnt;
    f = mk_frame(8'h1C, 1'b0);
    send_bits(f, 0, 9);
    check_bit("single ready before stop", rx_if.rx_data_ready, 1'b0);
    send_bits(f, 10, 10);
    check_bit("single ready after stop", rx_if.rx_data_ready, 1'b1);
    pop_check("single pop", 8'h1C);
    check_bit("single ready after pop", rx_if.rx_data_ready, 1'b0);
    check_int("single errors", err_cnt - e0, 0);
  endtask

  task automatic test_back_to_back;
    int e0;
    e0 = err_cnt;
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    pop_check("b2b pop0", 8'hF0);
    pop_check("b2b pop1", 8'h1C);
    check_int("b2b errors", err_cnt - e0, 0);
  endtask

  task automatic test_parity;
    int e0;
    e0 = err_cnt;
    send_frame(8'h1C, 1'b1);
    check_int("parity error pulses", err_cnt - e0, 1);
    check_bit("parity ready", rx_if.rx_data_ready, 1'b0);
    send_frame(8'h29, 1'b0);
    pop_check("parity recover", 8'h29);
  endtask

  task automatic test_timeout;
    int e0;
    e0 = err_cnt;
    send_bits(mk_frame(8'h77, 1'b0), 0, 4);
    ps2_data = 1'b1;
    repeat (28100) @(negedge clk);
    check_int("timeout error pulses", err_cnt - e0, 1);
    check_bit("timeout fsm idle", dut.state_q == StIdle, 1'b1);
    check_bit("timeout ready", rx_if.rx_data_ready, 1'b0);
    send_frame(8'h5A, 1'b0);
    pop_check("timeout recover", 8'h5A);
  endtask

  task automatic test_overflow;
    int o0;
    o0 = ovf_cnt;
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b0);
    check_int("ovf none after 4", ovf_cnt - o0, 0);
    send_frame(8'h05, 1'b0);
    check_int("ovf one after 5", ovf_cnt - o0, 1);
    pop_check("ovf pop1", 8'h01);
    pop_check("ovf pop2", 8'h02);
    pop_check("ovf pop3", 8'h03);
    pop_check("ovf pop4", 8'h04);
    check_bit("ovf drained", rx_if.rx_data_ready, 1'b0);
  endtask

  task automatic test_simul_push_pop;
    int o0;
    bit hit;
    o0 = ovf_cnt;
    hit = 1'b0;
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b0);
    send_bits(mk_frame(8'h05, 1'b0), 0, 9);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    for (int c = 0; c < HALF && !hit; c++) begin
      @(negedge clk);
      if (dut.push) hit = 1'b1;
    end
    check_bit("simul push seen", hit, 1'b1);
    rx_if.rx_read = 1'b1;
    @(negedge clk);
    rx_if.rx_read = 1'b0;
    check_int("simul popped", int'(rx_if.rx_scan_code), 1);
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (4) @(negedge clk);
    check_int("simul no ovf", ovf_cnt - o0, 0);
    pop_check("simul pop2", 8'h02);
    pop_check("simul pop3", 8'h03);
    pop_check("simul pop4", 8'h04);
    pop_check("simul pop5", 8'h05);
    check_bit("simul drained", rx_if.rx_data_ready, 1'b0);
  endtask

  task automatic test_glitch;
    int e0;
    e0 = err_cnt;
    @(negedge clk);
    ps2_clk = 1'b0;
    repeat (5) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (30) @(negedge clk);
    check_int("glitch errors", err_cnt - e0, 0);
    check_bit("glitch fsm idle", dut.state_q == StIdle, 1'b1);
  endtask

  task automatic test_reset_mid;
    send_frame(8'h33, 1'b0);
    send_bits(mk_frame(8'h44, 1'b0), 0, 4);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_int("rmid scan_code", int'(rx_if.rx_scan_code), 0);
    check_bit("rmid ready", rx_if.rx_data_ready, 1'b0);
    check_bit("rmid error", rx_if.rx_error, 1'b0);
    check_bit("rmid overflow", rx_if.rx_overflow, 1'b0);
    reset = 1'b1;
    ps2_data = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(8'h12, 1'b0);
    pop_check("rmid recover", 8'h12);
    check_bit("rmid drained", rx_if.rx_data_ready, 1'b0);
  endtask

  initial begin
    rx_if.rx_read = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_parity();
    test_timeout();
    test_overflow();
    test_simul_push_pop();
    test_glitch();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
